wm_panel_ctrl: RTL

// - Front-panel/supervisor side of the washing_machine start/done interface.
// - Debounces a raw start button, issues the one-cycle srt pulse, then watches fill/wash/rinse/spin/done.
// - Checks phase order and per-phase watchdog; reports busy, a sticky fault with code, and a completed-cycle count.

---
 rtl/wm_panel_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/wm_panel_ctrl.sv
// rtl/wm_panel_ctrl.sv - washing machine front-panel supervisor: debounced start/clear, srt pulse, phase-order watchdog
// Optional completion/fault buzzer is built only when WM_PANEL_BUZZER_EN is defined.

module wm_panel_debounce #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The level flips only after N consecutive synced samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 2'b00;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], raw};
            level_d <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = level & ~level_d;
endmodule

module wm_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PHASE_TIMEOUT   = 64,
    parameter int CNT_W           = 8,
    parameter int BUZZ_CYCLES     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_clear,
    input  logic             fill,
    input  logic             wash,
    input  logic             rinse,
    input  logic             spin,
    input  logic             done,
    output logic             srt,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] cycles_done,
    output logic             buzzer
);
    localparam int TW = $clog2(PHASE_TIMEOUT + 1);
    localparam logic [TW-1:0]    T_LIM   = TW'(PHASE_TIMEOUT);
    localparam logic [TW-1:0]    T_HIT   = TW'(PHASE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_ACK, RUN, COMPLETE, FAULT} state_t;

    state_t        state, state_n;
    logic [2:0]    exp_q, exp_n;
    logic [TW-1:0] timer, timer_n, timer_inc;
    logic [2:0]    code_n;
    logic          start_rise, clear_rise;
    logic [4:0]    ph, cur_bit, nxt_bit;
    logic          multi, hit;

    wm_panel_debounce #(.N(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .rst(rst), .raw(btn_start), .rise(start_rise)
    );
    wm_panel_debounce #(.N(DEBOUNCE_CYCLES)) u_db_clear (
        .clk(clk), .rst(rst), .raw(btn_clear), .rise(clear_rise)
    );

    assign ph        = {done, spin, rinse, wash, fill};
    assign multi     = (ph & (ph - 5'd1)) != 5'd0;
    assign cur_bit   = 5'd1 << exp_q;
    assign nxt_bit   = 5'd1 << (exp_q + 3'd1);
    assign hit       = timer >= T_HIT;
    assign timer_inc = (timer == T_LIM) ? timer : timer + TW'(1);

    // Fault checks are ordered so the lowest code wins when several fire together.
    always_comb begin
        state_n = state;
        exp_n   = exp_q;
        timer_n = timer;
        code_n  = fault_code;
        case (state)
            IDLE: if (start_rise) state_n = ARM;
            ARM: begin
                state_n = WAIT_ACK;
                timer_n = '0;
            end
            WAIT_ACK: begin
                if (fill) begin
                    state_n = RUN;
                    exp_n   = 3'd0;
                    timer_n = '0;
                end else if (hit) begin
                    state_n = FAULT;
                    code_n  = 3'd4;
                end else begin
                    timer_n = timer_inc;
                end
            end
            RUN: begin
                if (multi) begin
                    state_n = FAULT;
                    code_n  = 3'd1;
                end else if (ph == 5'd0 || ph == cur_bit) begin
                    if (hit) begin
                        state_n = FAULT;
                        code_n  = 3'd3;
                    end else begin
                        timer_n = timer_inc;
                    end
                end else if (ph == nxt_bit) begin
                    timer_n = '0;
                    if (exp_q == 3'd3) state_n = COMPLETE;
                    else               exp_n   = exp_q + 3'd1;
                end else begin
                    state_n = FAULT;
                    code_n  = 3'd2;
                end
            end
            COMPLETE: state_n = IDLE;
            FAULT: begin
                if (clear_rise) begin
                    state_n = IDLE;
                    code_n  = 3'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            exp_q       <= 3'd0;
            timer       <= '0;
            srt         <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            cycles_done <= '0;
        end else begin
            state      <= state_n;
            exp_q      <= exp_n;
            timer      <= timer_n;
            srt        <= (state_n == ARM);
            busy       <= (state_n inside {ARM, WAIT_ACK, RUN, COMPLETE});
            fault      <= (state_n == FAULT);
            fault_code <= code_n;
            if (state_n == COMPLETE && cycles_done != CNT_MAX)
                cycles_done <= cycles_done + CNT_W'(1);
        end
    end

`ifdef WM_PANEL_BUZZER_EN
    localparam int BW = $clog2(BUZZ_CYCLES + 1);
    logic [BW-1:0] buzz_cnt;
    logic          fault_entry;
    logic          trig;

    assign trig = (state == COMPLETE) || fault_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_cnt    <= '0;
            fault_entry <= 1'b0;
            buzzer      <= 1'b0;
        end else begin
            fault_entry <= (state_n == FAULT) && (state != FAULT);
            buzzer      <= trig || (buzz_cnt > BW'(1));
            if (trig)
                buzz_cnt <= BW'(BUZZ_CYCLES);
            else if (buzz_cnt != '0)
                buzz_cnt <= buzz_cnt - BW'(1);
        end
    end
`else
    logic unused_buzz_cfg;
    assign unused_buzz_cfg = (BUZZ_CYCLES > 0);
    assign buzzer = 1'b0;
`endif
endmodule
